// File: rtl/cpu_params_pkg.sv
// Shared CPU parameters: register width, CSR address map, mstatus/mip bit positions, interrupt causes.
// No logic; constants and one address-decode helper only.
// No flow control.
package cpu_params_pkg;

  localparam int RSZ = 32;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int IRQ_MSI_BIT = 3;
  localparam int IRQ_MTI_BIT = 7;
  localparam int IRQ_MEI_BIT = 11;
  localparam logic [RSZ-1:0] IRQ_MASK = 32'h0000_0888;

  localparam logic [RSZ-1:0] MCAUSE_MSI = 32'h8000_0003;
  localparam logic [RSZ-1:0] MCAUSE_MTI = 32'h8000_0007;
  localparam logic [RSZ-1:0] MCAUSE_MEI = 32'h8000_000B;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_M = 2'b11
  } priv_t;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH,
      CSR_MINSTRETH, CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH,
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_regs_counter64.sv
// 64-bit event counter with increment enable and independent low/high word write strobes.
// Latency: writes and increments visible one cycle later; a write to either half suppresses that cycle's increment.
// No backpressure.
module csr_counter64
  import cpu_params_pkg::*;
(
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             inc_en,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [RSZ-1:0]   wr_dat,
  output logic [2*RSZ-1:0] cnt
);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) cnt[RSZ-1:0]     <= wr_dat;
      if (wr_hi) cnt[2*RSZ-1:RSZ] <= wr_dat;
    end else if (inc_en) begin
      cnt <= cnt + 64'd1;
    end
  end

endmodule

// File: rtl/csr_regs.sv
// Machine/user CSR file: EXE read port, WB write commit, counters, trap entry / MRET, interrupt request.
// Latency: reads, trap_vector and irq outputs combinational; writes visible next cycle.
// No backpressure; csr_rd_avail drops for a same-address WB write so EXE stalls one cycle.
module csr_regs
  import cpu_params_pkg::*;
#(
  parameter logic [RSZ-1:0] MHARTID     = '0,
  parameter logic [RSZ-1:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [RSZ-1:0] MISA_VAL    = 32'h4000_1100
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic [11:0]    csr_addr,
  output logic [RSZ-1:0] csr_rd_data,
  output logic           csr_rd_avail,
  input  logic           wb_csr_wr,
  input  logic [11:0]    wb_csr_addr,
  input  logic [RSZ-1:0] wb_csr_wr_data,
  input  logic           retire,
  input  logic           trap_take,
  input  logic [RSZ-1:0] trap_pc,
  input  logic [RSZ-1:0] trap_cause,
  input  logic [RSZ-1:0] trap_tval,
  input  logic           mret,
  input  logic           ext_irq,
  input  logic           timer_irq,
  output logic [1:0]     mode,
  output logic [RSZ-1:0] trap_vector,
  output logic [RSZ-1:0] mepc_out,
  output logic           irq_req,
  output logic [RSZ-1:0] irq_cause
);

  priv_t            mode_q;
  priv_t            mst_mpp;
  logic             mst_mie;
  logic             mst_mpie;
  logic             msip_q;
  logic [RSZ-1:0]   mie_q;
  logic [RSZ-1:0]   mtvec_q;
  logic [RSZ-1:0]   mscratch_q;
  logic [RSZ-1:0]   mepc_q;
  logic [RSZ-1:0]   mcause_q;
  logic [RSZ-1:0]   mtval_q;
  logic [RSZ-1:0]   mstatus_val;
  logic [RSZ-1:0]   mip_val;
  logic [RSZ-1:0]   irq_pend;
  logic [RSZ-1:0]   vec_base;
  logic [2*RSZ-1:0] mcycle;
  logic [2*RSZ-1:0] minstret;
  logic             wd_mpp_legal;

  assign wd_mpp_legal = (wb_csr_wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == PRIV_U) ||
                        (wb_csr_wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == PRIV_M);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      mode_q     <= PRIV_M;
      mst_mpp    <= PRIV_M;
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      msip_q     <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= {RESET_MTVEC[RSZ-1:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (wb_csr_wr) begin
        case (wb_csr_addr)
          CSR_MIE:      mie_q <= wb_csr_wr_data & IRQ_MASK;
          CSR_MIP:      msip_q <= wb_csr_wr_data[IRQ_MSI_BIT];
          CSR_MSCRATCH: mscratch_q <= wb_csr_wr_data;
          CSR_MTVEC: begin
            mtvec_q[RSZ-1:2] <= wb_csr_wr_data[RSZ-1:2];
            // MODE 2/3 are reserved: keep the previous mode
            if (!wb_csr_wr_data[1]) mtvec_q[1:0] <= wb_csr_wr_data[1:0];
          end
          CSR_MSTATUS: begin
            if (!trap_take && !mret) begin
              mst_mie  <= wb_csr_wr_data[MSTATUS_MIE];
              mst_mpie <= wb_csr_wr_data[MSTATUS_MPIE];
              if (wd_mpp_legal) mst_mpp <= priv_t'(wb_csr_wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
            end
          end
          CSR_MEPC:   if (!trap_take) mepc_q <= wb_csr_wr_data & ~32'h3;
          CSR_MCAUSE: if (!trap_take) mcause_q <= wb_csr_wr_data;
          CSR_MTVAL:  if (!trap_take) mtval_q <= wb_csr_wr_data;
          default: ;
        endcase
      end

      if (trap_take) begin
        mepc_q   <= trap_pc & ~32'h3;
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
        mst_mpp  <= mode_q;
        mode_q   <= PRIV_M;
      end else if (mret) begin
        mode_q   <= mst_mpp;
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
        mst_mpp  <= PRIV_U;
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .inc_en   (1'b1),
    .wr_lo    (wb_csr_wr && (wb_csr_addr == CSR_MCYCLE)),
    .wr_hi    (wb_csr_wr && (wb_csr_addr == CSR_MCYCLEH)),
    .wr_dat   (wb_csr_wr_data),
    .cnt      (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .inc_en   (retire),
    .wr_lo    (wb_csr_wr && (wb_csr_addr == CSR_MINSTRET)),
    .wr_hi    (wb_csr_wr && (wb_csr_addr == CSR_MINSTRETH)),
    .wr_dat   (wb_csr_wr_data),
    .cnt      (minstret)
  );

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE]  = mst_mie;
    mstatus_val[MSTATUS_MPIE] = mst_mpie;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mst_mpp;
    mip_val = '0;
    mip_val[IRQ_MSI_BIT] = msip_q;
    mip_val[IRQ_MTI_BIT] = timer_irq;
    mip_val[IRQ_MEI_BIT] = ext_irq;
  end

  always_comb begin
    csr_rd_data = '0;
    case (csr_addr)
      CSR_MSTATUS:                  csr_rd_data = mstatus_val;
      CSR_MISA:                     csr_rd_data = MISA_VAL;
      CSR_MIE:                      csr_rd_data = mie_q;
      CSR_MTVEC:                    csr_rd_data = mtvec_q;
      CSR_MSCRATCH:                 csr_rd_data = mscratch_q;
      CSR_MEPC:                     csr_rd_data = mepc_q;
      CSR_MCAUSE:                   csr_rd_data = mcause_q;
      CSR_MTVAL:                    csr_rd_data = mtval_q;
      CSR_MIP:                      csr_rd_data = mip_val;
      CSR_MCYCLE,    CSR_CYCLE:     csr_rd_data = mcycle[RSZ-1:0];
      CSR_MCYCLEH,   CSR_CYCLEH:    csr_rd_data = mcycle[2*RSZ-1:RSZ];
      CSR_MINSTRET,  CSR_INSTRET:   csr_rd_data = minstret[RSZ-1:0];
      CSR_MINSTRETH, CSR_INSTRETH:  csr_rd_data = minstret[2*RSZ-1:RSZ];
      CSR_MHARTID:                  csr_rd_data = MHARTID;
      default:                      csr_rd_data = '0;
    endcase
  end

  // A same-cycle WB write to the read address would give EXE stale data
  assign csr_rd_avail = csr_implemented(csr_addr) &&
                        !(wb_csr_wr && (wb_csr_addr == csr_addr));

  assign vec_base    = {mtvec_q[RSZ-1:2], 2'b00};
  assign trap_vector = (mtvec_q[1:0] == 2'b01 && trap_cause[RSZ-1])
                       ? vec_base + {trap_cause[RSZ-3:0], 2'b00}
                       : vec_base;

  assign irq_pend = mip_val & mie_q;
  assign irq_req  = (|irq_pend) && ((mode_q == PRIV_U) || mst_mie);

  always_comb begin
    irq_cause = '0;
    if (irq_pend[IRQ_MEI_BIT])      irq_cause = MCAUSE_MEI;
    else if (irq_pend[IRQ_MSI_BIT]) irq_cause = MCAUSE_MSI;
    else if (irq_pend[IRQ_MTI_BIT]) irq_cause = MCAUSE_MTI;
  end

  assign mode     = mode_q;
  assign mepc_out = mepc_q;

endmodule

// File: doc/csr_regs.md
# csr_regs

Machine/user-mode Control & Status Register file: the responder side of the CSR functional-unit interface. Supplies current CSR contents and availability to the EXE-stage CSR unit, commits CSR writes from WB, and maintains the 64-bit cycle/instret counters. It also performs the architectural state updates for trap entry and MRET, and produces the interrupt-pending request for the pipeline controller.

## Interface
- RSZ, 32 (from cpu_params_pkg): register width.
- MHARTID, 0: value read at 12'hF14.
- RESET_MTVEC, 32'h0000_0000: mtvec reset value (MODE field forced 0).
- MISA_VAL, 32'h4000_1100: read-only misa value (RV32IM).

Ports:
- clk_in  in  1  system clock; one clock domain.
- reset_in  in  1  asynchronous, active-low reset.
- csr_addr  in  12  read address from EXE.
- csr_rd_data  out  RSZ  combinational contents of CSR[csr_addr].
- csr_rd_avail  out  1  address implemented and not hazarded.
- wb_csr_wr  in  1  commit write this cycle.
- wb_csr_addr  in  12  write address.
- wb_csr_wr_data  in  RSZ  write data.
- retire  in  1  one instruction retired this cycle.
- trap_take  in  1  enter trap this cycle.
- trap_pc  in  RSZ  PC saved to mepc.
- trap_cause  in  RSZ  mcause value; bit 31 = interrupt.
- trap_tval  in  RSZ  mtval value.
- mret  in  1  execute MRET this cycle.
- ext_irq, timer_irq  in  1 each  MEIP/MTIP sources.
- mode  out  2  current privilege: 2'b11 M, 2'b00 U.
- trap_vector  out  RSZ  handler target address.
- mepc_out  out  RSZ  mepc, for MRET redirect.
- irq_req  out  1  enabled interrupt pending.
- irq_cause  out  RSZ  cause for irq_req.

## Operation
- Implemented map: mstatus 300, misa 301 (RO), mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle/mcycleh B00/B80, minstret/minstreth B02/B82, cycle/cycleh C00/C80, instret/instreth C02/C82 (RO shadows), mvendorid/marchid/mimpid F11–F13 (read 0), mhartid F14.
- Any other address: csr_rd_avail=0, csr_rd_data=0, and writes to it are ignored.
- csr_rd_avail=0 also when wb_csr_wr and wb_csr_addr==csr_addr; EXE stalls one cycle.
- mstatus fields: MIE[3], MPIE[7], MPP[12:11]. All other bits read 0. MPP is WARL: writes of 01/10 keep the old value.
- mie and mip implement only bits 3, 7, 11.
  - mip[3] (MSIP) is software-writable.
  - mip[7] and mip[11] follow timer_irq and ext_irq directly and ignore writes.
- mtvec is WARL. A MODE write of 2/3 keeps the old MODE; BASE is always written. mepc[1:0] reads 0.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when retire=1.
  - Carry from the low to the high word occurs in the same cycle.
  - Both wrap at 2^64-1 to 0.
- Priority on the same cycle:
  - A WB write to a counter half wins over increment, and that counter does not increment this cycle.
  - trap_take beats mret. mret with trap_take is ignored.
  - trap_take with wb_csr_wr: the trap owns mepc/mcause/mtval/mstatus, and the write is dropped for those four. Writes to other CSRs commit.
- Trap entry: mepc←trap_pc&~3, mcause←trap_cause, mtval←trap_tval, MPIE←MIE, MIE←0, MPP←mode, mode←M.
- MRET: mode←MPP, MIE←MPIE, MPIE←1, MPP←00.
- trap_vector:
  - BASE when MODE=0, or when trap_cause[31]=0.
  - BASE+4·trap_cause[30:0] when MODE=1 and trap_cause[31]=1.
- irq_req = |(mip&mie) && (mode==U || MIE).
- irq_cause priority: MEIP (0x8000000B) > MSIP (0x80000003) > MTIP (0x80000007).

## Timing
- Reads, csr_rd_avail, trap_vector, irq_req and irq_cause are combinational, with zero latency.
- All writes and state updates occur on the rising clk_in edge and are visible the following cycle.
- A write at cycle N is readable at N+1.
- reset_in low asynchronously sets:
  - mode=M, mstatus=0x0000_1800 (MPP=11).
  - mtvec=RESET_MTVEC.
  - All other registers and counters 0; mip[3]=0.
- Reset during counting clears the counters immediately; counting resumes on the first edge after release.

## Structure
- Add CSR address localparams (CSR_MSTATUS … CSR_MHARTID), the mstatus bit-position constants and the mcause interrupt codes to cpu_params_pkg.
- Sub-module csr_counter64: 64-bit counter with increment enable and per-half write strobes. Instantiated twice (mcycle, minstret).

## Test plan
- Reset release, then read C00 for 3 cycles -> 0, 1, 2. Read 300 -> 0x1800, 305 -> RESET_MTVEC.
- Write mcycle=0xFFFF_FFFF, mcycleh=0, read one cycle later -> cycleh=1, cycle=0. minstret write with retire=1 -> written value, no increment.
- Write mtvec 0x8000_0003 -> reads 0x8000_0000 with MODE kept 0. Write 0x8000_0101 then trap_cause=0x8000_0007 -> trap_vector 0x8000_011C.
- mode=M, MIE=1, trap_take with trap_pc=0x123 -> next cycle mepc=0x120, MIE=0, MPIE=1, MPP=11. Then mret -> MIE=1, MPP=00, mode=M.
- mie=0x888, ext_irq=1, timer_irq=1, MIE=1 -> irq_req=1, irq_cause=0x8000000B. With MIE=0, mode=M -> irq_req=0.
- wb_csr_wr to 340 while csr_addr=340 -> csr_rd_avail=0 that cycle, 1 next cycle with new data. csr_addr=0x7C0 -> csr_rd_avail=0.
